ddr_stream_pkt_chk: RTL and testbench

//  Parametrised checker for DDR read-back streams. Frames packets as one header beat
//  (encoder word), N data beats and one end-flag beat; checks the data lanes and the

---
 rtl/ddr_stream_pkt_chk_if.sv | 18 +
 rtl/ddr_stream_pkt_chk.sv | 217 +++++++++++++++++++++
 tb/tb_ddr_stream_pkt_chk.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_stream_pkt_chk_if.sv
// ddr_stream_pkt_chk_if
//   Stream bus carrying DDR read-back beats into the packet checker.
//   There is no backpressure, so the bus has no tready.
// Signals
//   tdata   DATA_WD  stream data
//   tvalid  1        beat valid
// Modports
//   master  drives tdata/tvalid (source, e.g. width converter or bench)
//   slave   receives tdata/tvalid (checker)
interface ddr_stream_pkt_chk_if #(
  parameter int DATA_WD = 512
);
  logic [DATA_WD-1:0] tdata;
  logic               tvalid;

  modport master (output tdata, output tvalid);
  modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/ddr_stream_pkt_chk.sv
// ddr_stream_pkt_chk
//   Packet checker for DDR read-back streams. A packet is one header beat
//   carrying an encoder word, N data beats and one end-flag beat. Data
//   beats are checked for an internal lane ramp and for continuity with
//   the previous beat; header encoder words are checked for a fixed step.
//   Over-long packets are counted and the checker resynchronises on the
//   next end flag. All counters saturate at all-ones.
// Optional feature
//   DDR_CHK_ERR_CAPTURE_EN : when defined, adds a first-error capture
//   (err_cap_vld/exp/act/lane). Counting is identical either way.
// Ports
//   clk              stream clock
//   rst_n            synchronous active-low reset
//   cfg_rst          synchronous soft clear, active-high, beats this cycle dropped
//   s_axis           stream slave (tdata, tvalid)
//   adc_chk_suc_cnt  data beats passing the check
//   adc_chk_err_cnt  data beats failing the check
//   enc_chk_suc_cnt  headers passing the check
//   enc_chk_err_cnt  headers failing the check
//   pkt_cnt          packets closed by the end flag
//   len_err_cnt      packets exceeding MAX_BEATS data beats
//   chk_state        0 HEAD, 1 DATA, 2 RESYNC
//   err_cap_*        first data-error capture (optional)
module ddr_stream_pkt_chk #(
  parameter int                 DATA_WD   = 512,
  parameter int                 LANES     = 8,
  parameter int                 HEAD_WD   = 64,
  parameter logic [DATA_WD-1:0] END_FLAG  = DATA_WD'(64'h5A5ADEAD_0000FFFF),
  parameter int                 ENC_STEP  = 1,
  parameter int                 MAX_BEATS = 1024,
  localparam int                LANE_WD   = DATA_WD / LANES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_rst,
  ddr_stream_pkt_chk_if.slave       s_axis,
  output logic [31:0]               adc_chk_suc_cnt,
  output logic [31:0]               adc_chk_err_cnt,
  output logic [31:0]               enc_chk_suc_cnt,
  output logic [31:0]               enc_chk_err_cnt,
  output logic [31:0]               pkt_cnt,
  output logic [31:0]               len_err_cnt,
  output logic [1:0]                chk_state
`ifdef DDR_CHK_ERR_CAPTURE_EN
  ,
  output logic                      err_cap_vld,
  output logic [LANE_WD-1:0]        err_cap_exp,
  output logic [LANE_WD-1:0]        err_cap_act,
  output logic [7:0]                err_cap_lane
`endif
);

  // state  | meaning
  // HEAD   | waiting for a header beat; flag beats ignored
  // DATA   | inside a packet, checking data beats until the end flag
  // RESYNC | packet overran MAX_BEATS; dropping beats until the end flag
  typedef enum logic [1:0] {
    ST_HEAD   = 2'd0,
    ST_DATA   = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  localparam int                 BC_WD    = $clog2(MAX_BEATS + 1);
  localparam logic [LANE_WD-1:0] END_LANE = END_FLAG[LANE_WD-1:0];

  state_t state_q, state_nxt;

  logic               do_head, do_pkt, do_data, do_len;
  logic               clr;
  logic [BC_WD-1:0]   beat_cnt_q;
  logic               enc_seeded_q, dat_seeded_q;
  logic [HEAD_WD-1:0] enc_prev_q, enc;
  logic [LANE_WD-1:0] base_prev_q;
  logic [31:0]        adc_suc_q, adc_err_q, enc_suc_q, enc_err_q, pkt_q, len_q;

  logic [LANE_WD-1:0] lane [LANES];
  logic               is_flag;
  logic [LANES-1:0]   int_fail;
  logic               seq_fail;
  logic               enc_ok;

  assign clr = !rst_n || cfg_rst;
  assign enc = s_axis.tdata[HEAD_WD-1:0];

  always_comb begin
    is_flag  = 1'b0;
    int_fail = '0;
    for (int k = 0; k < LANES; k++) begin
      lane[k] = s_axis.tdata[k*LANE_WD +: LANE_WD];
      if (lane[k] == END_LANE) is_flag = 1'b1;
    end
    // Lane 0 defines the ramp, so it can only fail the continuity check.
    for (int k = 1; k < LANES; k++)
      int_fail[k] = (lane[k] != lane[0] + LANE_WD'(k));
    seq_fail = dat_seeded_q && (lane[0] != base_prev_q + LANE_WD'(LANES));
    enc_ok   = !enc_seeded_q || (enc == enc_prev_q + HEAD_WD'(ENC_STEP));
  end

  always_ff @(posedge clk) begin
    if (clr) state_q <= ST_HEAD;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    do_head   = 1'b0;
    do_pkt    = 1'b0;
    do_data   = 1'b0;
    do_len    = 1'b0;
    if (s_axis.tvalid) begin
      unique case (state_q)
        ST_HEAD: begin
          if (!is_flag) begin
            do_head   = 1'b1;
            state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          if (is_flag) begin
            do_pkt    = 1'b1;
            state_nxt = ST_HEAD;
          end else if (beat_cnt_q == BC_WD'(MAX_BEATS)) begin
            do_len    = 1'b1;
            state_nxt = ST_RESYNC;
          end else begin
            do_data   = 1'b1;
          end
        end
        ST_RESYNC: begin
          if (is_flag) state_nxt = ST_HEAD;
        end
        default: state_nxt = ST_HEAD;
      endcase
    end
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      beat_cnt_q   <= '0;
      enc_seeded_q <= 1'b0;
      dat_seeded_q <= 1'b0;
      enc_prev_q   <= '0;
      base_prev_q  <= '0;
      adc_suc_q    <= '0;
      adc_err_q    <= '0;
      enc_suc_q    <= '0;
      enc_err_q    <= '0;
      pkt_q        <= '0;
      len_q        <= '0;
    end else begin
      if (do_head) begin
        enc_prev_q   <= enc;
        enc_seeded_q <= 1'b1;
        beat_cnt_q   <= '0;
        dat_seeded_q <= 1'b0;
        if (enc_ok) enc_suc_q <= sat_inc(enc_suc_q);
        else        enc_err_q <= sat_inc(enc_err_q);
      end
      if (do_data) begin
        beat_cnt_q   <= beat_cnt_q + BC_WD'(1);
        base_prev_q  <= lane[0];
        dat_seeded_q <= 1'b1;
        if (int_fail == '0 && !seq_fail) adc_suc_q <= sat_inc(adc_suc_q);
        else                             adc_err_q <= sat_inc(adc_err_q);
      end
      if (do_pkt) pkt_q <= sat_inc(pkt_q);
      if (do_len) len_q <= sat_inc(len_q);
    end
  end

  assign adc_chk_suc_cnt = adc_suc_q;
  assign adc_chk_err_cnt = adc_err_q;
  assign enc_chk_suc_cnt = enc_suc_q;
  assign enc_chk_err_cnt = enc_err_q;
  assign pkt_cnt         = pkt_q;
  assign len_err_cnt     = len_q;
  assign chk_state       = state_q;

`ifdef DDR_CHK_ERR_CAPTURE_EN
  logic [LANE_WD-1:0] cap_exp, cap_act;
  logic [7:0]         cap_lane;

  // Lowest ramp-failing lane wins; lane 0 is reported only when the
  // continuity check alone failed.
  always_comb begin
    cap_lane = 8'd0;
    cap_exp  = base_prev_q + LANE_WD'(LANES);
    cap_act  = lane[0];
    for (int k = LANES - 1; k >= 1; k--) begin
      if (int_fail[k]) begin
        cap_lane = 8'(k);
        cap_exp  = lane[0] + LANE_WD'(k);
        cap_act  = lane[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      err_cap_vld  <= 1'b0;
      err_cap_exp  <= '0;
      err_cap_act  <= '0;
      err_cap_lane <= '0;
    end else if (do_data && !err_cap_vld && (int_fail != '0 || seq_fail)) begin
      err_cap_vld  <= 1'b1;
      err_cap_exp  <= cap_exp;
      err_cap_act  <= cap_act;
      err_cap_lane <= cap_lane;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_stream_pkt_chk.sv
module tb_ddr_stream_pkt_chk;
  localparam int DW   = 512;
  localparam int NL   = 8;
  localparam int LW   = DW / NL;
  localparam int MAXB = 4;
  localparam logic [63:0] EFLAG = 64'h5A5ADEAD_0000FFFF;

  logic clk = 1'b0;
  logic rst_n, cfg_rst;
  logic [31:0] adc_suc, adc_err, enc_suc, enc_err, pkts, lens;
  logic [1:0]  state;
`ifdef DDR_CHK_ERR_CAPTURE_EN
  logic          cap_vld;
  logic [LW-1:0] cap_exp, cap_act;
  logic [7:0]    cap_lane;
`endif

  ddr_stream_pkt_chk_if #(.DATA_WD(DW)) s_axis ();

  ddr_stream_pkt_chk #(
    .DATA_WD(DW), .LANES(NL), .HEAD_WD(64), .ENC_STEP(1), .MAX_BEATS(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst), .s_axis(s_axis),
    .adc_chk_suc_cnt(adc_suc), .adc_chk_err_cnt(adc_err),
    .enc_chk_suc_cnt(enc_suc), .enc_chk_err_cnt(enc_err),
    .pkt_cnt(pkts), .len_err_cnt(lens), .chk_state(state)
`ifdef DDR_CHK_ERR_CAPTURE_EN
    , .err_cap_vld(cap_vld), .err_cap_exp(cap_exp),
    .err_cap_act(cap_act), .err_cap_lane(cap_lane)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference model: packet-level view of the stream.
  int unsigned m_adc_suc, m_adc_err, m_enc_suc, m_enc_err, m_pkt, m_len;
  int          m_mode;       // 0 waiting header, 1 in packet, 2 dropping to flag
  int          m_beats;
  bit          m_enc_seeded, m_dat_seeded;
  logic [63:0] m_enc_prev, m_base_prev;
  bit          m_cap_vld;
  logic [63:0] m_cap_exp, m_cap_act;
  int          m_cap_lane;

  function automatic int unsigned sinc(input int unsigned v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic model_reset();
    m_adc_suc = 0; m_adc_err = 0; m_enc_suc = 0; m_enc_err = 0; m_pkt = 0; m_len = 0;
    m_mode = 0; m_beats = 0; m_enc_seeded = 0; m_dat_seeded = 0;
    m_enc_prev = '0; m_base_prev = '0;
    m_cap_vld = 0; m_cap_exp = '0; m_cap_act = '0; m_cap_lane = 0;
  endtask

  task automatic model_beat(input logic [DW-1:0] d);
    logic [63:0] ln [NL];
    bit flag = 0;
    int bad_lane = -1;
    bit seq_bad;
    for (int k = 0; k < NL; k++) begin
      ln[k] = d[k*LW +: LW];
      if (ln[k] == EFLAG) flag = 1;
    end
    if (m_mode == 0) begin
      if (!flag) begin
        if (!m_enc_seeded || ln[0] == m_enc_prev + 64'd1) m_enc_suc = sinc(m_enc_suc);
        else m_enc_err = sinc(m_enc_err);
        m_enc_seeded = 1; m_enc_prev = ln[0];
        m_mode = 1; m_beats = 0; m_dat_seeded = 0;
      end
    end else if (m_mode == 2) begin
      if (flag) m_mode = 0;
    end else if (flag) begin
      m_pkt = sinc(m_pkt); m_mode = 0;
    end else if (m_beats == MAXB) begin
      m_len = sinc(m_len); m_mode = 2;
    end else begin
      m_beats++;
      for (int k = NL - 1; k >= 1; k--)
        if (ln[k] != ln[0] + 64'(k)) bad_lane = k;
      seq_bad = m_dat_seeded && (ln[0] != m_base_prev + 64'(NL));
      if (bad_lane < 0 && !seq_bad) m_adc_suc = sinc(m_adc_suc);
      else begin
        m_adc_err = sinc(m_adc_err);
        if (!m_cap_vld) begin
          m_cap_vld = 1;
          if (bad_lane > 0) begin
            m_cap_lane = bad_lane; m_cap_exp = ln[0] + 64'(bad_lane); m_cap_act = ln[bad_lane];
          end else begin
            m_cap_lane = 0; m_cap_exp = m_base_prev + 64'(NL); m_cap_act = ln[0];
          end
        end
      end
      m_base_prev = ln[0]; m_dat_seeded = 1;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".adc_suc"}, 64'(adc_suc), 64'(m_adc_suc));
    chk({tag, ".adc_err"}, 64'(adc_err), 64'(m_adc_err));
    chk({tag, ".enc_suc"}, 64'(enc_suc), 64'(m_enc_suc));
    chk({tag, ".enc_err"}, 64'(enc_err), 64'(m_enc_err));
    chk({tag, ".pkt"},     64'(pkts),    64'(m_pkt));
    chk({tag, ".len"},     64'(lens),    64'(m_len));
    chk({tag, ".state"},   64'(state),   64'(m_mode));
`ifdef DDR_CHK_ERR_CAPTURE_EN
    chk({tag, ".cap_vld"}, 64'(cap_vld), 64'(m_cap_vld));
    if (m_cap_vld) begin
      chk({tag, ".cap_lane"}, 64'(cap_lane), 64'(m_cap_lane));
      chk({tag, ".cap_exp"},  64'(cap_exp),  m_cap_exp);
      chk({tag, ".cap_act"},  64'(cap_act),  m_cap_act);
    end
`endif
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [63:0] base);
    logic [DW-1:0] d;
    for (int k = 0; k < NL; k++) d[k*LW +: LW] = base + 64'(k);
    return d;
  endfunction

  function automatic logic [DW-1:0] mk_head(input logic [63:0] enc);
    logic [DW-1:0] d;
    for (int k = 0; k < NL; k++) d[k*LW +: LW] = {$urandom, $urandom} | 64'h1;
    d[63:0] = enc;
    return d;
  endfunction

  function automatic logic [DW-1:0] mk_flag();
    logic [DW-1:0] d;
    int p = $urandom_range(NL - 1, 0);
    for (int k = 0; k < NL; k++) d[k*LW +: LW] = {$urandom, $urandom} | 64'h1;
    d[p*LW +: LW] = EFLAG;
    return d;
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic v);
    @(negedge clk);
    s_axis.tdata  = d;
    s_axis.tvalid = v;
    if (v) model_beat(d);
    @(posedge clk);
    #1;
    s_axis.tvalid = 1'b0;
  endtask

  task automatic soft_clr(input logic with_beat, input logic [DW-1:0] d);
    @(negedge clk);
    cfg_rst       = 1'b1;
    s_axis.tdata  = d;
    s_axis.tvalid = with_beat;
    @(posedge clk);
    #1;
    cfg_rst       = 1'b0;
    s_axis.tvalid = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [63:0]   gen_enc, gen_base;
    int            r;

    rst_n = 1'b0; cfg_rst = 1'b0;
    s_axis.tdata = '0; s_axis.tvalid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_model("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // T1: two clean packets
    send(mk_head(64'h10), 1);
    for (int i = 0; i < 4; i++) send(mk_data(64'(8 * i)), 1);
    send(mk_flag(), 1);
    send(mk_head(64'h11), 1);
    for (int i = 0; i < 4; i++) send(mk_data(64'(8 * i)), 1);
    send(mk_flag(), 1);
    chk("t1.adc_suc", 64'(adc_suc), 64'd8);
    chk("t1.adc_err", 64'(adc_err), 64'd0);
    chk("t1.enc_suc", 64'(enc_suc), 64'd2);
    chk("t1.pkt",     64'(pkts),    64'd2);

    // flag in HEAD and idle beats change nothing
    send(mk_flag(), 1);
    send(mk_head(64'h77), 0);
    chk_model("idle");

    // T2: lane 5 of the third beat corrupted
    soft_clr(0, '0);
    send(mk_head(64'h20), 1);
    send(mk_data(64'd0), 1);
    send(mk_data(64'd8), 1);
    d = mk_data(64'd16);
    d[5*LW +: LW] = 64'd0;
    send(d, 1);
    send(mk_data(64'd24), 1);
    chk("t2.adc_err", 64'(adc_err), 64'd1);
    chk("t2.adc_suc", 64'(adc_suc), 64'd3);
`ifdef DDR_CHK_ERR_CAPTURE_EN
    chk("t2.cap_lane", 64'(cap_lane), 64'd5);
    chk("t2.cap_exp",  64'(cap_exp),  64'd21);
    chk("t2.cap_act",  64'(cap_act),  64'd0);
`endif
    send(mk_flag(), 1);

    // T3: encoder step error, then encoder wrap
    soft_clr(0, '0);
    send(mk_head(64'h10), 1); send(mk_flag(), 1);
    send(mk_head(64'h12), 1); send(mk_flag(), 1);
    chk("t3.enc_suc", 64'(enc_suc), 64'd1);
    chk("t3.enc_err", 64'(enc_err), 64'd1);
    soft_clr(0, '0);
    send(mk_head(64'hFFFF_FFFF_FFFF_FFFF), 1); send(mk_flag(), 1);
    send(mk_head(64'h0), 1); send(mk_flag(), 1);
    chk("t3w.enc_err", 64'(enc_err), 64'd0);
    chk("t3w.enc_suc", 64'(enc_suc), 64'd2);

    // lane wrap inside a beat and across beats
    send(mk_head(64'h1), 1);
    send(mk_data(64'hFFFF_FFFF_FFFF_FFFC), 1);
    send(mk_data(64'h4), 1);
    chk("wrap.adc_suc", 64'(adc_suc), 64'd2);
    chk("wrap.adc_err", 64'(adc_err), 64'd0);
    send(mk_flag(), 1);

    // T4: over-long packet
    soft_clr(0, '0);
    send(mk_head(64'h30), 1);
    for (int i = 0; i < 6; i++) send(mk_data(64'(100 + 8 * i)), 1);
    chk("t4.state_resync", 64'(state), 64'd2);
    send(mk_flag(), 1);
    chk("t4.adc_suc", 64'(adc_suc), 64'd4);
    chk("t4.len",     64'(lens),    64'd1);
    chk("t4.pkt",     64'(pkts),    64'd0);
    chk("t4.state",   64'(state),   64'd0);

    // T5: soft clear with a valid beat mid-packet
    soft_clr(0, '0);
    send(mk_head(64'h40), 1);
    send(mk_data(64'd0), 1);
    send(mk_data(64'd8), 1);
    soft_clr(1, mk_data(64'd16));
    chk_model("t5.clr");
    send(mk_head(64'h55), 1);
    chk("t5.enc_suc", 64'(enc_suc), 64'd1);
    chk("t5.enc_err", 64'(enc_err), 64'd0);

    // T6: error counter saturation
    @(negedge clk);
    force dut.adc_err_q = 32'hFFFF_FFFE;
    #1;
    release dut.adc_err_q;
    m_adc_err = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      d = mk_data(64'(200 + 8 * i));
      d[2*LW +: LW] = 64'd0;
      send(d, 1);
    end
    chk("t6.adc_err", 64'(adc_err), 64'hFFFF_FFFF);
    send(mk_flag(), 1);
    chk_model("t6");

    // randomized stream against the model
    soft_clr(0, '0);
    gen_enc  = {$urandom, $urandom};
    gen_base = 64'hFFFF_FFFF_FFFF_FFF0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99, 0);
      if (r < 8) begin
        send(mk_flag(), 0);
      end else if (r < 22) begin
        send(mk_flag(), 1);
      end else if (r < 36) begin
        gen_enc = ($urandom_range(3, 0) == 0) ? {$urandom, $urandom} : gen_enc + 64'd1;
        if (gen_enc == EFLAG) gen_enc = 64'h0;
        send(mk_head(gen_enc), 1);
        gen_base = ($urandom_range(1, 0) == 0) ? {$urandom, $urandom} : 64'hFFFF_FFFF_FFFF_FFFC;
      end else if (r < 38) begin
        soft_clr($urandom_range(1, 0) == 1, mk_data(gen_base));
      end else begin
        d = mk_data(gen_base);
        if ($urandom_range(9, 0) == 0)
          d[$urandom_range(NL - 1, 0)*LW +: LW] ^= 64'h1 << $urandom_range(63, 0);
        if ($urandom_range(14, 0) == 0) d = mk_data({$urandom, $urandom});
        send(d, 1);
        gen_base = d[LW-1:0] + 64'(NL);
      end
      chk_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
